// File: rtl/stat_pkg.sv
// ---------------------------------------------------------------------------
// stat_pkg
// Shared definitions for the statistics result path:
//   - default widths of the min/sum/avg fields
//   - stat_entry_t : one captured run {min, sum, avg} (MSB..LSB)
//   - fifo_state_e : FIFO status EMPTY / PARTIAL / FULL
//   - min_of       : helper returning the smaller of two minima
// ---------------------------------------------------------------------------
package stat_pkg;

  localparam int STAT_MIN_W    = 8;
  localparam int STAT_SUM_W    = 13;
  localparam int STAT_LOG2_NUM = 5;
  localparam int STAT_AVG_W    = STAT_SUM_W - STAT_LOG2_NUM;

  // Storage layout of one FIFO entry; the FIFO packs entries in this order.
  typedef struct packed {
    logic [STAT_MIN_W-1:0] min;
    logic [STAT_SUM_W-1:0] sum;
    logic [STAT_AVG_W-1:0] avg;
  } stat_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

  function automatic logic [STAT_MIN_W-1:0] min_of(
    input logic [STAT_MIN_W-1:0] a,
    input logic [STAT_MIN_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/stat_fifo_mem.sv
// ---------------------------------------------------------------------------
// stat_fifo_mem
// DEPTH x EW register array with one synchronous write port and one
// asynchronous read port. Contents are not reset (don't care when empty).
// Ports:
//   Clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_ptr   in   write address
//   wr_data  in   entry to store
//   rd_ptr   in   read address
//   rd_data  out  entry at rd_ptr (combinational)
// ---------------------------------------------------------------------------
module stat_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int EW    = 29
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem [DEPTH];

  // Entry storage write port.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/stat_result_fifo.sv
// ---------------------------------------------------------------------------
// stat_result_fifo
// Captures {min, sum, avg} of every completed statistics run (rising edge of
// done_in) into a DEPTH-entry FIFO and presents the head via valid/ready.
// A push into a full FIFO with no simultaneous pop is dropped and sets the
// sticky overflow flag, so the producer never stalls.
// Ports:
//   Clk        in   clock, rising edge
//   Rst        in   asynchronous active-low reset
//   done_in    in   run done (level)
//   min_in     in   run minimum, valid while done_in=1
//   sum_in     in   run sum, valid while done_in=1
//   out_valid  out  head entry valid
//   out_ready  in   consumer takes head
//   out_min    out  head minimum (0 while empty)
//   out_sum    out  head sum     (0 while empty)
//   out_avg    out  head average (0 while empty)
//   count      out  entries held
//   overflow   out  sticky dropped-run flag
//   clr_ovf    in   synchronous overflow clear (a same-cycle drop wins)
//   global_min out  running minimum of accepted runs
// Optional feature macro: MIN_TRACK_EN (global_min tracking; when undefined
// global_min is tied to all-ones).
// ---------------------------------------------------------------------------
module stat_result_fifo
  import stat_pkg::*;
#(
  parameter int MIN_W    = STAT_MIN_W,
  parameter int SUM_W    = STAT_SUM_W,
  parameter int LOG2_NUM = STAT_LOG2_NUM,
  parameter int DEPTH    = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      done_in,
  input  logic [MIN_W-1:0]          min_in,
  input  logic [SUM_W-1:0]          sum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MIN_W-1:0]          out_min,
  output logic [SUM_W-1:0]          out_sum,
  output logic [SUM_W-LOG2_NUM-1:0] out_avg,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_ovf,
  output logic [MIN_W-1:0]          global_min
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int AVG_W = SUM_W - LOG2_NUM;
  localparam int EW    = MIN_W + SUM_W + AVG_W;

  logic          done_q;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt;
  logic          overflow_r;
  fifo_state_e   state_r;
  fifo_state_e   state_nxt;

  logic          push;
  logic          pop;
  logic          full;
  logic          wr_accept;
  logic          drop;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;

  assign push      = done_in & ~done_q;
  assign out_valid = (state_r != ST_EMPTY);
  assign full      = (state_r == ST_FULL);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign wr_accept = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Same layout as stat_entry_t: {min, sum, avg}; avg is a truncating shift.
  assign wr_data = {min_in, sum_in, sum_in[SUM_W-1:LOG2_NUM]};

  stat_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .EW    (EW)
  ) u_mem (
    .Clk     (Clk),
    .wr_en   (wr_accept),
    .wr_ptr  (wr_ptr_r),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_r),
    .rd_data (rd_data)
  );

  assign {out_min, out_sum, out_avg} = out_valid ? rd_data : {EW{1'b0}};
  assign count    = count_r;
  assign overflow = overflow_r;

  // Occupancy counter next value.
  always_comb begin
    count_nxt = count_r;
    case ({wr_accept, pop})
      2'b10:   count_nxt = count_r + CW'(1);
      2'b01:   count_nxt = count_r - CW'(1);
      default: count_nxt = count_r;
    endcase
  end

  // FIFO status next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (wr_accept) begin
          state_nxt = ST_PARTIAL;
        end else begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_PARTIAL: begin
        if (wr_accept && !pop && (count_r == CW'(DEPTH - 1))) begin
          state_nxt = ST_FULL;
        end else if (pop && !wr_accept && (count_r == CW'(1))) begin
          state_nxt = ST_EMPTY;
        end else begin
          state_nxt = ST_PARTIAL;
        end
      end
      ST_FULL: begin
        if (pop && !wr_accept) begin
          state_nxt = ST_PARTIAL;
        end else begin
          state_nxt = ST_FULL;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Edge detector, pointers, counter, status and sticky overflow.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      done_q     <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      state_r    <= ST_EMPTY;
      overflow_r <= 1'b0;
    end else begin
      done_q   <= done_in;
      wr_ptr_r <= wr_accept ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
      rd_ptr_r <= pop ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      count_r  <= count_nxt;
      state_r  <= state_nxt;
      if (drop) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

`ifdef MIN_TRACK_EN
  logic [MIN_W-1:0] global_min_r;

  // Running minimum over accepted pushes only.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      global_min_r <= {MIN_W{1'b1}};
    end else if (wr_accept && (min_in < global_min_r)) begin
      global_min_r <= min_in;
    end else begin
      global_min_r <= global_min_r;
    end
  end

  assign global_min = global_min_r;
`else
  assign global_min = {MIN_W{1'b1}};
`endif

endmodule

// File: tb/tb_stat_result_fifo.sv
module tb_stat_result_fifo;

  logic        Clk;
  logic        Rst;
  logic        done_in;
  logic [7:0]  min_in;
  logic [12:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_min;
  logic [12:0] out_sum;
  logic [7:0]  out_avg;
  logic [2:0]  count;
  logic        overflow;
  logic        clr_ovf;
  logic [7:0]  global_min;

  int checks;
  int errors;

  stat_result_fifo dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .done_in    (done_in),
    .min_in     (min_in),
    .sum_in     (sum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_sum    (out_sum),
    .out_avg    (out_avg),
    .count      (count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .global_min (global_min)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle done pulse, called and returning at a falling edge.
  task automatic pulse(input logic [7:0] m, input logic [12:0] s);
    done_in = 1'b1;
    min_in  = m;
    sum_in  = s;
    @(negedge Clk);
    done_in = 1'b0;
    @(negedge Clk);
  endtask

  logic [7:0] exp_mins [4];

  initial begin
    checks    = 0;
    errors    = 0;
    Rst       = 1'b0;
    done_in   = 1'b0;
    min_in    = 8'd0;
    sum_in    = 13'd0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    @(negedge Clk);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_count", count, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_min", out_min, 0);
    check_val("rst_gmin", global_min, 8'hFF);
    Rst = 1'b1;
    @(negedge Clk);

    // done held high for 3 cycles -> one entry
    done_in = 1'b1; min_in = 8'h05; sum_in = 13'd4000;
    @(negedge Clk);
    check_val("hold_valid_next", out_valid, 1);
    check_val("hold_count_next", count, 1);
    @(negedge Clk);
    @(negedge Clk);
    done_in = 1'b0;
    @(negedge Clk);
    check_val("hold_count", count, 1);
    check_val("hold_min", out_min, 5);
    check_val("hold_sum", out_sum, 4000);
    check_val("hold_avg", out_avg, 125);
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    check_val("pop_count", count, 0);
    check_val("pop_valid", out_valid, 0);
    check_val("pop_min_zero", out_min, 0);

    // five pulses into DEPTH=4
    for (int i = 1; i <= 5; i++) pulse(8'(i), 13'(100 * i));
    check_val("ovf_count", count, 4);
    check_val("ovf_flag", overflow, 1);
    check_val("ovf_head", out_min, 1);
    check_val("ovf_head_sum", out_sum, 100);
    clr_ovf = 1'b1;
    @(negedge Clk);
    clr_ovf = 1'b0;
    check_val("clr_ovf", overflow, 0);

    // full: push and pop in the same cycle
    done_in = 1'b1; min_in = 8'd9; sum_in = 13'd900; out_ready = 1'b1;
    @(negedge Clk);
    done_in = 1'b0; out_ready = 1'b0;
    check_val("fullpp_count", count, 4);
    check_val("fullpp_ovf", overflow, 0);
    @(negedge Clk);
    exp_mins[0] = 8'd2; exp_mins[1] = 8'd3; exp_mins[2] = 8'd4; exp_mins[3] = 8'd9;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("drain_min%0d", i), out_min, exp_mins[i]);
      if (i == 3) begin
        check_val("tail_sum", out_sum, 900);
        check_val("tail_avg", out_avg, 28);
      end
      out_ready = 1'b1;
      @(negedge Clk);
    end
    out_ready = 1'b0;
    check_val("drain_count", count, 0);
    check_val("drain_valid", out_valid, 0);

    // avg boundaries
    pulse(8'd0, 13'd8191);
    check_val("avg_8191", out_avg, 255);
    out_ready = 1'b1; @(negedge Clk); out_ready = 1'b0;
    pulse(8'd0, 13'd31);
    check_val("avg_31", out_avg, 0);
    check_val("sum_31", out_sum, 31);
    out_ready = 1'b1; @(negedge Clk); out_ready = 1'b0;
    pulse(8'd0, 13'd8160);
    check_val("avg_8160", out_avg, 255);
    out_ready = 1'b1; @(negedge Clk); out_ready = 1'b0;
    check_val("ready_empty_count", count, 0);

    // async reset mid-cycle with 3 entries
    pulse(8'd1, 13'd10);
    pulse(8'd2, 13'd20);
    pulse(8'd3, 13'd30);
    check_val("pre_rst_count", count, 3);
    #2;
    Rst = 1'b0;
    #1;
    check_val("async_valid", out_valid, 0);
    check_val("async_count", count, 0);
    @(negedge Clk);
    Rst = 1'b1;
    out_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
    check_val("post_rst_count", count, 0);
    check_val("post_rst_valid", out_valid, 0);

    // running minimum
    pulse(8'd40, 13'd0);
    pulse(8'd12, 13'd0);
    pulse(8'd200, 13'd0);
    check_val("gmin_count", count, 3);
`ifdef MIN_TRACK_EN
    check_val("gmin", global_min, 12);
`else
    check_val("gmin", global_min, 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stat_result_fifo.md
Name: stat_result_fifo

Overview:
- Downstream consumer of the min/sum statistics engine (go/done/min/sum interface).
- Detects each completed run on the rising edge of done and captures {min, sum, avg} into a small FIFO.
- Presents captured results to the reporting/display stage through a valid/ready handshake.
- Keeps a sticky overflow flag so the statistics engine never has to stall.

Parameters:
- MIN_W, 8, width of min input/output
- SUM_W, 13, width of sum input/output
- LOG2_NUM, 5, log2 of elements per run (32); avg = sum >> LOG2_NUM
- DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- done_in  input  1  done from statistics engine (level; may stay high several cycles)
- min_in  input  MIN_W  run minimum, valid while done_in=1
- sum_in  input  SUM_W  run sum, valid while done_in=1
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_min  output  MIN_W  head minimum
- out_sum  output  SUM_W  head sum
- out_avg  output  SUM_W-LOG2_NUM  head average (8 bits by default)
- count  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky: a run was dropped
- clr_ovf  input  1  synchronous clear of overflow
- global_min  output  MIN_W  running minimum (see Optional Feature)

Behaviour:
- Reset (Rst=0, async): done_q=0, rd/wr pointers=0, count=0, out_valid=0, overflow=0, global_min=all-ones; storage contents don't care. out_min/out_sum/out_avg read 0 while empty.
- Edge detect: done_q <= done_in every cycle. push = done_in & ~done_q. A done held high for N cycles yields one push. done already high when reset releases yields a push on the first cycle.
- Capture is same-edge: entry {min_in, sum_in, sum_in[SUM_W-1:LOG2_NUM]} is written on the push edge. out_valid and count update one cycle after the push.
- avg: truncating shift, no rounding. E.g. sum=8160 -> avg=255; sum=31 -> avg=0.
- pop = out_valid & out_ready. Head advances on the same edge. out_* is combinational from storage[rd_ptr].
- Pointers: $clog2(DEPTH) bits, wrap naturally. count is a separate counter.
- Push and pop both occur in one cycle:
  - Not full: both happen, count unchanged.
  - Full: push is accepted because the pop frees a slot; count stays DEPTH.
  - Empty: pop is impossible (out_valid=0), so only the push happens.
- Push while full with no pop: entry dropped, pointers unchanged, overflow<=1.
- clr_ovf=1 clears overflow, unless a drop occurs in the same cycle; the drop wins and overflow stays 1.
- out_ready while empty: ignored.
- Reset mid-operation: all entries discarded immediately. out_valid falls asynchronously.
- Internal FSM per FIFO status: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push without pop at count=DEPTH-1.
  - FULL->PARTIAL on pop without push.
  - PARTIAL->EMPTY on pop without push at count=1.
  - out_valid = (state!=EMPTY). full = (state==FULL).

Optional Feature:
- Macro MIN_TRACK_EN.
- Defined: on every accepted push, global_min <= min(global_min, min_in). Dropped pushes do not update it. Reset value is all-ones.
- Undefined: no tracking register; global_min is tied to all-ones.

Decomposition:
- Package stat_pkg:
  - MIN_W, SUM_W and LOG2_NUM defaults.
  - Entry struct/typedef {min, sum, avg}.
  - FIFO status enum {EMPTY, PARTIAL, FULL}.
- One natural sub-module: stat_fifo_mem. It holds the DEPTH x entry register array, with write port (wr_en, wr_ptr, data) and asynchronous read (rd_ptr).
- Edge detect, pointers, FSM and overflow stay in the top level.

Test Plan:
- Reset, then hold done_in=1 for 3 cycles with min=8'h05, sum=13'd4000 -> exactly one entry; out_valid=1 next cycle; out_min=5, out_sum=4000, out_avg=125; count=1.
- Five done pulses with out_ready=0 (DEPTH=4) -> count=4, first four entries retained in order, overflow=1. clr_ovf -> overflow=0.
- FIFO full, then done pulse and out_ready=1 in the same cycle -> count stays 4; head advances; new entry at tail; overflow stays 0.
- sum=13'd8191 -> out_avg=255. sum=13'd31 -> out_avg=0.
- Assert Rst=0 with 3 entries held, mid-cycle -> out_valid=0 and count=0 immediately, before the next edge. After release, out_ready pops nothing.
- MIN_TRACK_EN: pushes with min=40, 12, 200 -> global_min=12. Without the macro -> global_min=8'hFF.
